adder_stream_harness: RTL and testbench

Parametrised on-chip stimulus/response harness for streaming arithmetic DUTs such as the lab adders. It streams operand pairs from an internal operand memory into the DUT using a valid/ready handshake, one vector per cycle. It collects in-order results (sum and carry) into an internal result memory, and reports completion and error status. It replaces the fixed 32-bit, non-backpressured test wrapper, which used an external BRAM, with configurable width, depth and run length.

---
 rtl/adder_stream_harness.sv | 175 +++++++++++++++++
 tb/tb_adder_stream_harness.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_stream_harness.sv
// Streams operand pairs from internal memory to an arithmetic DUT over valid/ready, one per cycle.
// First vector is issued 2 cycles after start. Results are never backpressured. Optional watchdog: ADDER_HARNESS_TIMEOUT_EN.
module adder_stream_harness #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_vecs,
  input  logic                       cin_cfg,
  output logic                       busy,
  output logic                       done,
  output logic                       err_overflow,
  output logic                       err_timeout,
  input  logic                       load_en,
  input  logic                       load_sel,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [DATA_W-1:0]          load_data,
  input  logic                       rd_sel,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [DATA_W-1:0]          a,
  output logic [DATA_W-1:0]          b,
  output logic                       cin,
  output logic                       valid_in,
  input  logic                       in_ready,
  input  logic [DATA_W-1:0]          s,
  input  logic                       cout,
  input  logic                       valid_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("adder_stream_harness: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [DATA_W-1:0] opa_mem   [DEPTH];
  logic [DATA_W-1:0] opb_mem   [DEPTH];
  logic [DATA_W-1:0] res_s_mem [DEPTH];
  logic              res_c_mem [DEPTH];

  logic [AW:0] n_vecs;
  logic [AW:0] fetch_cnt;    // vectors loaded into a/b
  logic [AW:0] issue_cnt;    // vectors accepted by the DUT
  logic [AW:0] res_cnt;      // results collected
  logic [AW:0] outstanding;

  logic [AW:0] n_eff;
  logic        active;
  logic        accept;
  logic        collect;
  logic        overflow;
  logic        fetch;
  logic        timeout_hit;

  always_comb begin
    n_eff    = (num_vecs == '0 || num_vecs > DEPTH_V) ? DEPTH_V : num_vecs;
    active   = (state == RUN) || (state == DRAIN);
    accept   = valid_in && in_ready;
    collect  = active && valid_out && (outstanding != '0);
    overflow = active && valid_out && (outstanding == '0);
    // Refill a/b when the output register is empty or being consumed this cycle.
    fetch    = (state == RUN) && (!valid_in || in_ready) && (fetch_cnt != n_vecs);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid_in     <= 1'b0;
      a            <= '0;
      b            <= '0;
      cin          <= 1'b0;
      err_overflow <= 1'b0;
      n_vecs       <= '0;
      fetch_cnt    <= '0;
      issue_cnt    <= '0;
      res_cnt      <= '0;
      outstanding  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            n_vecs       <= n_eff;
            cin          <= cin_cfg;
            err_overflow <= 1'b0;
            fetch_cnt    <= '0;
            issue_cnt    <= '0;
            res_cnt      <= '0;
            outstanding  <= '0;
          end
        end
        default: begin
          if (fetch) begin
            a         <= opa_mem[fetch_cnt[AW-1:0]];
            b         <= opb_mem[fetch_cnt[AW-1:0]];
            valid_in  <= 1'b1;
            fetch_cnt <= fetch_cnt + 1'b1;
          end else if (accept) begin
            valid_in <= 1'b0;
          end

          if (accept)   issue_cnt    <= issue_cnt + 1'b1;
          if (collect)  res_cnt      <= res_cnt + 1'b1;
          if (overflow) err_overflow <= 1'b1;

          if (accept && !collect)      outstanding <= outstanding + 1'b1;
          else if (!accept && collect) outstanding <= outstanding - 1'b1;

          if ((collect && res_cnt == n_vecs - 1'b1) || timeout_hit) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            valid_in <= 1'b0;
          end else if (state == RUN && accept && issue_cnt == n_vecs - 1'b1) begin
            state <= DRAIN;
          end
        end
      endcase
    end
  end

`ifdef ADDER_HARNESS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_cnt;

  assign timeout_hit = active && !accept && !valid_out && (wd_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if ((state == IDLE || state == DONE) && start) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (active) begin
      if (accept || valid_out) wd_cnt <= '0;
      else if (timeout_hit)    err_timeout <= 1'b1;
      else                     wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Memories carry no reset; only the readback register does.
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      if (load_sel) opb_mem[load_addr] <= load_data;
      else          opa_mem[load_addr] <= load_data;
    end
    if (collect) begin
      res_s_mem[res_cnt[AW-1:0]] <= s;
      res_c_mem[res_cnt[AW-1:0]] <= cout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         rd_data <= '0;
    else if (rd_sel) rd_data <= {{(DATA_W-1){1'b0}}, res_c_mem[rd_addr]};
    else             rd_data <= res_s_mem[rd_addr];
  end

endmodule

// File: tb/tb_adder_stream_harness.sv
// Bench for adder_stream_harness with a 1-cycle adder model; issued operands are
// scoreboarded against a queue filled at each start, results are read back and recomputed.
module tb_adder_stream_harness;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, cin_cfg, load_en, load_sel, rd_sel, in_ready, inj;
  logic [AW:0]       num_vecs;
  logic [AW-1:0]     load_addr, rd_addr;
  logic [DATA_W-1:0] load_data, rd_data, a, b, s;
  logic              busy, done, err_overflow, err_timeout, cin, valid_in, cout, valid_out;

  adder_stream_harness #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vecs(num_vecs), .cin_cfg(cin_cfg),
    .busy(busy), .done(done), .err_overflow(err_overflow), .err_timeout(err_timeout),
    .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data), .a(a), .b(b), .cin(cin),
    .valid_in(valid_in), .in_ready(in_ready), .s(s), .cout(cout), .valid_out(valid_out)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle adder model; returns at most ret_lim results per run.
  logic              mvld;
  logic [DATA_W-1:0] ms;
  logic              mc;
  int                ret_cnt, ret_lim;
  always @(posedge clk) begin
    if (rst || start) begin
      mvld    <= 1'b0;
      ret_cnt <= 0;
    end else begin
      mvld <= 1'b0;
      if (valid_in && in_ready && ret_cnt < ret_lim) begin
        mvld      <= 1'b1;
        {mc, ms}  <= {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
        ret_cnt   <= ret_cnt + 1;
      end
    end
  end
  assign valid_out = mvld | inj;
  assign s         = mvld ? ms : 32'hDEAD_BEEF;
  assign cout      = mvld ? mc : 1'b1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [DATA_W-1:0] va;
    logic [DATA_W-1:0] vb;
  } vec_t;
  vec_t op_q[$];
  int   acc_cnt = 0;
  int   acc_cyc[32];
  int   last_vo = 0;

  // Issue monitor: every presented vector must match the queue head, stalls included.
  always @(negedge clk) begin
    if (start) acc_cnt = 0;
    if (valid_out) last_vo = cyc;
    if (valid_in) begin
      if (op_q.size() == 0) begin
        check("extra_issue", 64'(valid_in), 64'd0);
      end else begin
        check("issue_a", a, op_q[0].va);
        check("issue_b", b, op_q[0].vb);
        if (in_ready) begin
          void'(op_q.pop_front());
          if (acc_cnt < 32) acc_cyc[acc_cnt] = cyc;
          acc_cnt++;
        end
      end
    end
  end

  logic [DATA_W-1:0] ma[DEPTH];
  logic [DATA_W-1:0] mb[DEPTH];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_pat(input int mode, input int w);
    case (mode)
      0:       return 1'b1;
      1:       return (w % 4 == 0) || (w % 4 == 3);
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_run(input int nv, input logic c, input int mode, input bit do_inj,
                        input int rlim, input bit want_done, input int wait_cyc, output int t0);
    int  n;
    bit  got;
    n = (nv == 0 || nv > DEPTH) ? DEPTH : nv;
    for (int k = 0; k < n; k++) op_q.push_back({ma[k], mb[k]});
    ret_lim  = rlim;
    num_vecs = (AW+1)'(nv);
    cin_cfg  = c;
    in_ready = rdy_pat(mode, 0);
    start    = 1'b1;
    t0       = cyc;
    step();
    start    = 1'b0;
    inj      = do_inj;
    in_ready = rdy_pat(mode, 1);
    @(negedge clk);
    check("busy_at_t1", busy, 1);
    check("valid_in_at_t1", valid_in, 0);
    got = 1'b0;
    for (int w = 2; w < wait_cyc; w++) begin
      step();
      inj      = 1'b0;
      in_ready = rdy_pat(mode, w);
      @(negedge clk);
      if (want_done && done) begin
        got = 1'b1;
        break;
      end
    end
    if (want_done) begin
      check("done_seen", 64'(got), 64'd1);
      check("busy_at_done", busy, 0);
      check("done_after_last_result", 64'(cyc), 64'(last_vo + 1));
    end
  endtask

  task automatic readback(input int n, input logic c);
    logic [DATA_W:0] sum;
    for (int k = 0; k < n; k++) begin
      sum = {1'b0, ma[k]} + {1'b0, mb[k]} + {{DATA_W{1'b0}}, c};
      step();
      rd_sel  = 1'b0;
      rd_addr = AW'(k);
      step();
      @(negedge clk);
      check("rd_sum", rd_data, sum[DATA_W-1:0]);
      step();
      rd_sel = 1'b1;
      step();
      @(negedge clk);
      check("rd_carry", rd_data, {31'd0, sum[DATA_W]});
    end
  endtask

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; cin_cfg = 1'b0; load_en = 1'b0; load_sel = 1'b0;
    rd_sel = 1'b0; in_ready = 1'b0; inj = 1'b0; num_vecs = '0;
    load_addr = '0; rd_addr = '0; load_data = '0; ret_lim = 1000;

    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid_in", valid_in, 0);
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_cin", cin, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_rd_data", rd_data, 0);
    step();
    rst = 1'b0;

    for (int k = 0; k < DEPTH; k++) begin
      ma[k] = DATA_W'(k + 1);
      mb[k] = (k < 8) ? 32'hFFFF_FFFF : $urandom;
      load_en = 1'b1; load_sel = 1'b0; load_addr = AW'(k); load_data = ma[k];
      step();
      load_sel = 1'b1; load_data = mb[k];
      step();
    end
    load_en = 1'b0;

    // Back-to-back run of 8.
    do_run(8, 1'b0, 0, 1'b0, 1000, 1'b1, 400, t0);
    check("run1_accepts", 64'(acc_cnt), 64'd8);
    for (int k = 0; k < 8; k++) check("run1_accept_cycle", 64'(acc_cyc[k]), 64'(t0 + 2 + k));
    readback(8, 1'b0);

    // Same run under a stalling DUT.
    do_run(8, 1'b0, 1, 1'b0, 1000, 1'b1, 400, t0);
    check("run2_accepts", 64'(acc_cnt), 64'd8);
    readback(8, 1'b0);

    // num_vecs=0 means DEPTH; carry-in 1.
    do_run(0, 1'b1, 0, 1'b0, 1000, 1'b1, 400, t0);
    check("run3_accepts", 64'(acc_cnt), 64'd16);
    check("run3_cin", cin, 1);
    readback(16, 1'b1);

    do_run(3, 1'b0, 0, 1'b0, 1000, 1'b1, 400, t0);
    check("run4_accepts", 64'(acc_cnt), 64'd3);
    readback(3, 1'b0);

    // num_vecs above DEPTH clamps to DEPTH.
    do_run(20, 1'b0, 1, 1'b0, 1000, 1'b1, 400, t0);
    check("run5_accepts", 64'(acc_cnt), 64'd16);

    // Spurious result before anything is outstanding.
    do_run(4, 1'b0, 0, 1'b1, 1000, 1'b1, 400, t0);
    check("run6_err_overflow", err_overflow, 1);
    check("run6_accepts", 64'(acc_cnt), 64'd4);
    readback(4, 1'b0);

    // DUT returns only the first result.
    do_run(8, 1'b0, 0, 1'b0, 1, 1'b0, 100, t0);
    check("run7_accepts", 64'(acc_cnt), 64'd8);
    check("run7_err_overflow_cleared", err_overflow, 0);
`ifdef ADDER_HARNESS_TIMEOUT_EN
    check("run7_done", done, 1);
    check("run7_err_timeout", err_timeout, 1);
`else
    check("run7_busy_waits", busy, 1);
    check("run7_not_done", done, 0);
    check("run7_err_timeout", err_timeout, 0);
    step();
    start = 1'b1;
    num_vecs = 5'd8;
    step();
    start = 1'b0;
    @(negedge clk);
    check("start_while_busy_busy", busy, 1);
    check("start_while_busy_valid_in", valid_in, 0);
`endif
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    op_q.delete();

    // Reset mid-run while stalled in RUN; a load during the run must be ignored.
    do_run(8, 1'b0, 2, 1'b0, 1000, 1'b0, 6, t0);
    check("run8_stalled_valid_in", valid_in, 1);
    step();
    load_en = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = 32'h1234_5678;
    step();
    load_en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    op_q.delete();
    @(negedge clk);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_valid_in", valid_in, 0);
    check("midrun_rst_done", done, 0);

    do_run(8, 1'b0, 0, 1'b0, 1000, 1'b1, 400, t0);
    check("run9_accepts", 64'(acc_cnt), 64'd8);
    check("run9_first_accept_cycle", 64'(acc_cyc[0]), 64'(t0 + 2));
    readback(8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
